// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: FSM states, the buffered
// entry layout and the halt encoding.
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 10;
  localparam int FETCH_DATA_WIDTH = 9;
  localparam logic [FETCH_DATA_WIDTH-1:0] HALT_WORD_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] instr;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of control, instruction-memory and decode-side signals around the
// fetch sequencer; master is the sequencer, slave is its surroundings.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 9
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  busy;
  logic                  halted;

  modport master (
    input  start, start_addr, redirect, redirect_pc, imem_instr, instr_ready,
    output imem_addr, instr_valid, instr, instr_pc, busy, halted
  );

  modport slave (
    output start, start_addr, redirect, redirect_pc, imem_instr, instr_ready,
    input  imem_addr, instr_valid, instr, instr_pc, busy, halted
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a flush that clears it in one
// cycle; the head reads as zero whenever the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  entry_t           wdata_i,
  output entry_t           rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Flush wins over both push and pop; depth is a power of two so pointers wrap freely.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wrPtr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = empty_o ? entry_t'('0) : mem_q[rdPtr_q];

  assert property (@(posedge clk) disable iff (!rst_n) !(flush_i == 1'b0 && pop_i && empty_o));
  assert property (@(posedge clk) disable iff (!rst_n) !(flush_i == 1'b0 && push_i && !pop_i && full_o));

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: fetches one word per cycle into a small FIFO toward
// decode, with start, branch redirect (flush) and halt-word detection.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  push, pop, flush;
  logic                  fifoFull, fifoEmpty;
  logic [CNT_W-1:0]      fifoCount;
  entry_t                pushEntry, headEntry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pop = !fifoEmpty && bus.instr_ready;

  // Redirect beats fetch; a halt word is still enqueued so decode observes it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = bus.start_addr;
        end
      end
      HALTED: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = bus.start_addr;
          flush   = 1'b1;
        end
      end
      RUN: begin
        if (bus.redirect) begin
          flush = 1'b1;
          pc_d  = bus.redirect_pc;
        end else if (!fifoFull || pop) begin
          push = 1'b1;
          pc_d = pc_q + ADDR_WIDTH'(1);
          if (bus.imem_instr == HALT_WORD) state_d = HALTED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pushEntry = '{instr: bus.imem_instr, pc: pc_q};

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (pushEntry),
    .rdata_o (headEntry),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = !fifoEmpty;
  assign bus.instr       = headEntry.instr;
  assign bus.instr_pc    = headEntry.pc;
  assign bus.busy        = (state_q == RUN);
  assign bus.halted      = (state_q == HALTED);

  assert property (@(posedge clk) disable iff (!rst_n) fifoCount <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_fetch_sequencer;

  localparam int AW    = 10;
  localparam int DW    = 9;
  localparam int DEPTH = 2;
  localparam int SPAN  = 1 << AW;
  localparam int HALT  = 'h1FF;

  typedef struct {
    int instr;
    int pc;
  } ent_t;

  logic clk;
  logic rst_n;
  logic [DW-1:0] imem [SPAN];

  fetch_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .HALT_WORD  (9'h1FF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_instr = imem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 running, 2 halted; FIFO contents as a queue.
  int   mState;
  int   mPc;
  ent_t mq[$];
  int   checkCount;
  int   passCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s @%0t: got %0h, expected %0h", tag, $time, observed, expected);
  endtask

  task automatic checkAll();
    int expInstr;
    int expPc;
    expInstr = (mq.size() > 0) ? mq[0].instr : 0;
    expPc    = (mq.size() > 0) ? mq[0].pc : 0;
    checkOutput("imem_addr",   32'(bus.imem_addr),   32'(mPc));
    checkOutput("instr_valid", 32'(bus.instr_valid), 32'(mq.size() > 0));
    checkOutput("instr",       32'(bus.instr),       32'(expInstr));
    checkOutput("instr_pc",    32'(bus.instr_pc),    32'(expPc));
    checkOutput("busy",        32'(bus.busy),        32'(mState == 1));
    checkOutput("halted",      32'(bus.halted),      32'(mState == 2));
  endtask

  task automatic modelReset();
    mState = 0;
    mPc    = 0;
    mq.delete();
  endtask

  task automatic applyStimulus(input bit st, input int sa, input bit rd, input int rpc, input bit rdy);
    bus.start       = st;
    bus.start_addr  = AW'(sa);
    bus.redirect    = rd;
    bus.redirect_pc = AW'(rpc);
    bus.instr_ready = rdy;
  endtask

  // Advance the model by one clock using the inputs currently applied, then
  // let the DUT take the same edge and compare.
  task automatic runCycle();
    ent_t e;
    if (mq.size() > 0 && bus.instr_ready) void'(mq.pop_front());
    case (mState)
      0: if (bus.start) begin
           mState = 1;
           mPc    = int'(bus.start_addr);
         end
      2: if (bus.start) begin
           mq.delete();
           mState = 1;
           mPc    = int'(bus.start_addr);
         end
      default: begin
        if (bus.redirect) begin
          mq.delete();
          mPc = int'(bus.redirect_pc);
        end else if (mq.size() < DEPTH) begin
          e.instr = int'(imem[mPc]);
          e.pc    = mPc;
          mq.push_back(e);
          if (e.instr == HALT) mState = 2;
          mPc = (mPc + 1) % SPAN;
        end
      end
    endcase
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  // Pulse reset between clock edges and verify the outputs clear at once.
  task automatic asyncReset();
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    applyStimulus(0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int i = 0; i < SPAN; i++) imem[i] = DW'($urandom_range(0, HALT - 1));
    for (int i = 'h100; i < 'h1F0; i++) if ($urandom_range(0, 19) == 0) imem[i] = DW'(HALT);
    imem[0] = 9'h010;
    imem[1] = 9'h011;
    imem[2] = 9'h012;
    imem[3] = DW'(HALT);

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line program ending in a halt.
    applyStimulus(1, 0, 0, 0, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 1);
    runCycles(8);

    // Backpressure: two entries buffered, PC stalled, then in-order drain.
    applyStimulus(1, 0, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0);
    runCycles(5);
    checkOutput("bp_stall_pc", 32'(bus.imem_addr), 32'd2);
    applyStimulus(0, 0, 0, 0, 1);
    runCycles(6);

    // Redirect while PCs 4 and 5 are buffered.
    applyStimulus(1, 4, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0);
    runCycles(2);
    applyStimulus(0, 0, 1, 'h200, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 1);
    runCycle();
    checkOutput("redir_target_pc", 32'(bus.instr_pc), 32'h200);
    runCycles(2);

    // Start while running is ignored.
    applyStimulus(1, 'h3FE, 0, 0, 1);
    runCycles(3);

    // Fill the FIFO, then reset mid-cycle; start is needed to resume.
    applyStimulus(0, 0, 0, 0, 0);
    runCycles(3);
    asyncReset();
    runCycles(3);

    // PC wrap from the top of memory into the halt at address 3.
    applyStimulus(1, SPAN - 2, 0, 0, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 1);
    runCycles(8);

    // Redirect while halted is ignored.
    applyStimulus(0, 0, 1, 'h50, 1);
    runCycles(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, SPAN - 1),
                    $urandom_range(0, 7) == 0, $urandom_range(0, SPAN - 1),
                    $urandom_range(0, 3) != 0);
      runCycle();
      if ($urandom_range(0, 149) == 0) asyncReset();
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
